async_receiver: RTL and testbench
=================================

// Module: async_receiver
// PURPOSE
//  Downstream partner of the serial transmitter. Deserialises its one-bit-per-CLK frame
//  on RXD: start bit 0, WIDTH data bits MSB first, stop bit 1. Checks framing and holds
//  each received word in a one-entry output register until the consumer acknowledges it.
//  Sits between the serial link and the display/consumer logic, in the same CLK domain.
// PARAMETERS
//  WIDTH        8   data bits per frame
//  SYNC_STAGES  2   input synchroniser flops on RXD. 0 = RXD used directly.
// PORTS
//  CLK       in   1      single system clock, rising edge
//  RST       in   1      asynchronous, active-high reset
//  RXD       in   1      serial line, idles high
//  RX_ACK    in   1      consumer takes RX_DATA. Meaningful only while RX_VALID=1.
//  RX_DATA   out  WIDTH  last accepted word
//  RX_VALID  out  1      RX_DATA holds an unread word (level)
//  RX_BUSY   out  1      frame in progress (DATA or STOP state)
//  RX_FERR   out  1      framing error, sticky
//  RX_OVR    out  1      overrun, sticky
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, shift reg=0, bit count=0, sync flops=1.
//   Outputs: RX_DATA=0, RX_VALID=0, RX_BUSY=0, RX_FERR=0, RX_OVR=0.
//   A partial frame in progress is discarded.
//  rxd_s = RXD delayed by SYNC_STAGES flops. All decisions below use rxd_s.
//  FSM encodings IDLE=2'd0, DATA=2'd1, STOP=2'd2. 2'd3 -> IDLE (self-correction).
//   IDLE: rxd_s==0 -> DATA, bit count=0. Any low level counts as a start bit.
//   DATA: each cycle shift <= {shift[WIDTH-2:0], rxd_s} and count++.
//         After the WIDTH-th bit (count==WIDTH-1) -> STOP.
//   STOP: sample rxd_s, then go to IDLE.
//         rxd_s==1 -> frame good.
//         rxd_s==0 -> RX_FERR<=1, word dropped, RX_VALID unchanged.
//  Timing: 1 start + WIDTH data + 1 stop cycle. Good frame sets RX_VALID at the edge
//   that ends STOP, i.e. SYNC_STAGES+WIDTH+2 cycles after RXD first goes low.
//   A new start bit is accepted in the first cycle after STOP.
//  Good-frame delivery:
//   RX_VALID==0, or RX_ACK==1 in the same cycle -> RX_DATA<=shift, RX_VALID<=1.
//    Simultaneous ACK + delivery: the new word wins and RX_VALID stays 1.
//   RX_VALID==1 and no RX_ACK -> new word dropped, RX_OVR<=1, RX_DATA unchanged.
//  RX_ACK with RX_VALID==1 and no delivery -> RX_VALID<=0 next cycle.
//   RX_ACK while RX_VALID==0 is ignored.
//  RX_FERR and RX_OVR clear only on RST or on an accepted RX_ACK. The clear is lower
//   priority than a set in the same cycle.
//  RX_BUSY = (state!=IDLE), registered with the state.
// STRUCTURE
//  Shared package/include (uart_defs): state encodings IDLE/DATA/STOP, FRAME_LEN =
//   WIDTH+2, line idle level 1'b1. The transmitter uses the same constants.
//  Sub-module rx_sync: SYNC_STAGES-deep flop chain with async reset to 1.
//   Pass-through when SYNC_STAGES=0.
//  Top level holds the FSM, bit counter ($clog2(WIDTH) bits), shift reg and output regs.
// TESTING (bench drives RXD one bit per CLK; loopback from the transmitter also required)
//  1 Frame 0xA5, RX_ACK held 0 -> RX_VALID rises SYNC_STAGES+10 cycles after the start
//    edge, RX_DATA=8'hA5, RX_FERR=0.
//  2 Stop bit forced 0 on frame 0x3C -> RX_FERR=1, RX_VALID stays 0, RX_DATA=0.
//    Next good frame 0x11 is delivered normally.
//  3 Frames 0x01 then 0x02 back-to-back, no ACK -> RX_DATA=8'h01, RX_OVR=1.
//    One RX_ACK -> RX_VALID=0, RX_OVR=0.
//  4 RX_ACK asserted exactly in the STOP cycle of frame 0x7E while 0x55 is held ->
//    RX_DATA=8'h7E, RX_VALID=1, RX_OVR=0.
//  5 RST pulsed after 4 data bits of frame 0xFF, RXD then idle -> all outputs 0,
//    RX_BUSY=0 immediately. No spurious word after RST releases.
//  6 Loopback: transmitter sends 0x00, 0xFF, 0x80 -> each received exactly once, in order.

Source files
------------

// File: rtl/async_receiver_pkg.sv
// Constants shared by the serial transmitter and receiver: FSM encodings and line levels.
package async_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam int   DEF_WIDTH = 8;
  localparam int   FRAME_LEN = DEF_WIDTH + 2;

  function automatic int frame_len(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/async_receiver_rx_sync.sv
// RXD synchroniser: SYNC_STAGES flops resetting to the idle line level; wire when 0.
module async_receiver_rx_sync
  import async_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sync_q <= {SYNC_STAGES{LINE_IDLE}};
      end else begin
        sync_q[0] <= d;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign q = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/async_receiver.sv
// Serial frame receiver: start 0, WIDTH bits MSB first, stop 1, one-entry output holding register.
module async_receiver
  import async_receiver_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RXD,
  input  logic             RX_ACK,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             RX_BUSY,
  output logic             RX_FERR,
  output logic             RX_OVR
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             rxd_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en, cnt_clr, frame_good, frame_bad;
  logic             ack_taken, deliver;

  async_receiver_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (RXD),
    .q   (rxd_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      RX_BUSY <= 1'b0;
    end else begin
      state_q <= state_d;
      RX_BUSY <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: state_d = (cnt_q == LAST_BIT) ? ST_STOP : ST_DATA;
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_en   = (state_q == ST_DATA);
    cnt_clr    = (state_q == ST_IDLE) && !rxd_s;
    frame_good = (state_q == ST_STOP) &&  rxd_s;
    frame_bad  = (state_q == ST_STOP) && !rxd_s;
  end

  // An ACK only counts while a word is held; delivery may reuse the slot it frees.
  assign ack_taken = RX_ACK && RX_VALID;
  assign deliver   = frame_good && (!RX_VALID || RX_ACK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      if (cnt_clr)       cnt_q <= '0;
      else if (shift_en) cnt_q <= cnt_q + 1'b1;
      if (shift_en) shift_q <= (shift_q << 1) | WIDTH'(rxd_s);
    end
  end

  // Flag sets take priority over the ACK clear in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      RX_FERR  <= 1'b0;
      RX_OVR   <= 1'b0;
    end else begin
      if (deliver) begin
        RX_DATA  <= shift_q;
        RX_VALID <= 1'b1;
      end else if (ack_taken) begin
        RX_VALID <= 1'b0;
      end
      if (frame_bad)      RX_FERR <= 1'b1;
      else if (ack_taken) RX_FERR <= 1'b0;
      if (frame_good && !deliver) RX_OVR <= 1'b1;
      else if (ack_taken)         RX_OVR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_receiver.sv
// Scoreboarded bench for async_receiver: directed frames, random frames and a transmitter loopback.
module tb_async_receiver;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RXD = 1'b1;
  logic         RX_ACK = 1'b0;
  logic [W-1:0] RX_DATA;
  logic         RX_VALID, RX_BUSY, RX_FERR, RX_OVR;

  async_receiver #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXD      (RXD),
    .RX_ACK   (RX_ACK),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_BUSY  (RX_BUSY),
    .RX_FERR  (RX_FERR),
    .RX_OVR   (RX_OVR)
  );

  always #5 CLK = ~CLK;

  int           n_chk = 0, n_pass = 0;
  int           cyc = 0;
  int           start_cyc, valid_rise_cyc;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tx_q[$];
  logic         auto_ack = 1'b0;
  logic         tx_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One bit per cycle: start, data MSB first, stop.
  task automatic send_frame(input logic [W-1:0] w, input logic stop);
    logic [W+1:0] bits;
    bits = {1'b0, w, stop};
    start_cyc = cyc;
    for (int i = W + 1; i >= 0; i--) begin
      RXD = bits[i];
      tick(1);
    end
    RXD = 1'b1;
  endtask

  task automatic ack_pulse();
    RX_ACK = 1'b1;
    tick(1);
    RX_ACK = 1'b0;
  endtask

  task automatic do_reset();
    RXD = 1'b1;
    RX_ACK = 1'b0;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a new word is on RX_DATA when VALID rises, or stays high right after an accepted ACK.
  initial begin
    logic prev_valid, prev_taken;
    logic [W-1:0] e;
    prev_valid = 1'b0;
    prev_taken = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_valid = 1'b0;
        prev_taken = 1'b0;
      end else begin
        if (RX_VALID && (!prev_valid || prev_taken)) begin
          valid_rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(RX_DATA), 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'(RX_DATA), 32'(e));
          end
        end
        prev_valid = RX_VALID;
        prev_taken = RX_VALID && RX_ACK;
      end
    end
  end

  // Consumer that acknowledges every held word one cycle after it appears.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (auto_ack) RX_ACK = RX_VALID && !RX_ACK;
    end
  end

  // Bench-side transmitter for the loopback test: drains tx_q back to back.
  initial begin
    logic [W-1:0] w;
    forever begin
      @(posedge CLK);
      #1;
      if (tx_q.size() != 0) begin
        tx_busy = 1'b1;
        while (tx_q.size() != 0) begin
          w = tx_q.pop_front();
          send_frame(w, 1'b1);
        end
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    logic bad;
    int n;

    #2;
    chk("rst_data", 32'(RX_DATA), 32'd0);
    chk("rst_valid", 32'(RX_VALID), 32'd0);
    chk("rst_busy", 32'(RX_BUSY), 32'd0);
    chk("rst_ferr", 32'(RX_FERR), 32'd0);
    chk("rst_ovr", 32'(RX_OVR), 32'd0);
    tick(1);
    RST = 1'b0;
    tick(2);

    // 1: single frame, latency and data
    valid_rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("t1_timeout", 20);
    chk("t1_latency", 32'(valid_rise_cyc - start_cyc), 32'(SS + W + 2));
    chk("t1_data", 32'(RX_DATA), 32'hA5);
    chk("t1_ferr", 32'(RX_FERR), 32'd0);

    // 2: bad stop bit, then a good frame
    do_reset();
    send_frame(8'h3C, 1'b0);
    tick(SS + 2);
    chk("t2_ferr", 32'(RX_FERR), 32'd1);
    chk("t2_valid", 32'(RX_VALID), 32'd0);
    chk("t2_data", 32'(RX_DATA), 32'd0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_drain("t2_timeout", 20);
    chk("t2_data2", 32'(RX_DATA), 32'h11);
    chk("t2_ferr_sticky", 32'(RX_FERR), 32'd1);

    // 3: overrun
    do_reset();
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    tick(SS + 2);
    chk("t3_data", 32'(RX_DATA), 32'h01);
    chk("t3_ovr", 32'(RX_OVR), 32'd1);
    chk("t3_valid", 32'(RX_VALID), 32'd1);
    ack_pulse();
    chk("t3_valid_ack", 32'(RX_VALID), 32'd0);
    chk("t3_ovr_ack", 32'(RX_OVR), 32'd0);

    // 4: ACK in the STOP cycle of the next frame
    do_reset();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("t4_timeout", 20);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    tick(SS - 1);
    ack_pulse();
    chk("t4_data", 32'(RX_DATA), 32'h7E);
    chk("t4_valid", 32'(RX_VALID), 32'd1);
    chk("t4_ovr", 32'(RX_OVR), 32'd0);
    wait_drain("t4_timeout2", 4);

    // 5: reset mid-frame
    do_reset();
    exp_q.push_back(8'h9C);
    send_frame(8'h9C, 1'b1);
    wait_drain("t5_timeout", 20);
    for (int i = 0; i < 5; i++) begin
      RXD = (i != 0);
      tick(1);
    end
    tick(SS);
    chk("t5_busy_pre", 32'(RX_BUSY), 32'd1);
    RST = 1'b1;
    RXD = 1'b1;
    #2;
    chk("t5_busy", 32'(RX_BUSY), 32'd0);
    chk("t5_valid", 32'(RX_VALID), 32'd0);
    chk("t5_data", 32'(RX_DATA), 32'd0);
    chk("t5_flags", 32'({RX_FERR, RX_OVR}), 32'd0);
    tick(1);
    RST = 1'b0;
    tick(30);
    chk("t5_no_word", 32'(RX_VALID), 32'd0);

    // 6: loopback through the bench transmitter with a prompt consumer
    do_reset();
    auto_ack = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h80);
    n = 0;
    while ((tx_q.size() != 0 || tx_busy) && n < 200) begin
      tick(1);
      n++;
    end
    wait_drain("t6_timeout", 20);
    chk("t6_ovr", 32'(RX_OVR), 32'd0);

    // Random frames, occasional framing errors, random idle gaps
    for (int k = 0; k < 24; k++) begin
      w = W'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      if (!bad) exp_q.push_back(w);
      send_frame(w, !bad);
      if (bad) begin
        tick(SS + 1);
        chk("rnd_ferr", 32'(RX_FERR), 32'd1);
      end
      tick($urandom_range(0, 3));
    end
    wait_drain("rnd_timeout", 40);
    chk("rnd_ovr", 32'(RX_OVR), 32'd0);
    auto_ack = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
